// File: rtl/bib_veri_hakemi.sv
// bib_veri_hakemi: round-robin arbiter that shares one data-memory port
// between CEKIRDEK_SAYISI core request ports.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   cek_sec_i            per-core request valid
//   cek_adr_i            per-core address, channel k at [k*ADRES_BIT +: ADRES_BIT]
//   cek_veri_i           per-core write data
//   cek_veri_maske_i     per-core byte mask (all zero = read)
//   cek_veri_o           per-core read data (only the released channel is non-zero)
//   cek_durdur_o         per-core stall
//   bel_*_o / bel_*_i    downstream memory request / response
//   hata_o               one-cycle timeout pulse
//   hata_kanal_o         channel of the most recent timeout
//
// States
//   BOS    | idle, arbitrate among requesters
//   MESGUL | downstream request outstanding
//   YANIT  | one-cycle release of the granted core
module bib_veri_hakemi #(
  parameter int CEKIRDEK_SAYISI = 2,
  parameter int VERI_BIT        = 32,
  parameter int ADRES_BIT       = 32,
  parameter int ZAMAN_ASIMI     = 1024,
  localparam int N  = CEKIRDEK_SAYISI,
  localparam int KW = (N > 1) ? $clog2(N) : 1,
  localparam int MW = VERI_BIT / 8,
  localparam int SW = (ZAMAN_ASIMI > 0) ? $clog2(ZAMAN_ASIMI + 1) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N-1:0]           cek_sec_i,
  input  logic [N*ADRES_BIT-1:0] cek_adr_i,
  input  logic [N*VERI_BIT-1:0]  cek_veri_i,
  input  logic [N*MW-1:0]        cek_veri_maske_i,
  output logic [N*VERI_BIT-1:0]  cek_veri_o,
  output logic [N-1:0]           cek_durdur_o,
  output logic                   bel_sec_o,
  output logic [ADRES_BIT-1:0]   bel_adr_o,
  output logic [VERI_BIT-1:0]    bel_veri_o,
  output logic [MW-1:0]          bel_veri_maske_o,
  input  logic [VERI_BIT-1:0]    bel_veri_i,
  input  logic                   bel_durdur_i,
  output logic                   hata_o,
  output logic [KW-1:0]          hata_kanal_o
);

  typedef enum logic [1:0] {BOS, MESGUL, YANIT} durum_t;

  durum_t               durum_q, durum_d;
  logic [KW-1:0]        oncelik_q, oncelik_d;
  logic [KW-1:0]        kanal_q, kanal_d;
  logic [ADRES_BIT-1:0] adr_q, adr_d;
  logic [VERI_BIT-1:0]  veri_q, veri_d;
  logic [MW-1:0]        maske_q, maske_d;
  logic [VERI_BIT-1:0]  yanit_veri_q, yanit_veri_d;
  logic [SW-1:0]        bekleme_sayaci_q, bekleme_sayaci_d;
  logic                 hata_q, hata_d;
  logic [KW-1:0]        hata_kanal_q, hata_kanal_d;
  logic [KW-1:0]        secilen;

  // Walk offsets from largest to smallest so the requester closest to
  // oncelik (offset 0 first) is the last assignment and wins.
  always_comb begin
    secilen = oncelik_q;
    for (int i = N - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(oncelik_q) + i) % N;
      if (cek_sec_i[idx]) secilen = KW'(idx);
    end
  end

  always_comb begin
    durum_d          = durum_q;
    oncelik_d        = oncelik_q;
    kanal_d          = kanal_q;
    adr_d            = adr_q;
    veri_d           = veri_q;
    maske_d          = maske_q;
    yanit_veri_d     = yanit_veri_q;
    bekleme_sayaci_d = bekleme_sayaci_q;
    hata_d           = 1'b0;
    hata_kanal_d     = hata_kanal_q;
    case (durum_q)
      BOS: begin
        if (|cek_sec_i) begin
          durum_d          = MESGUL;
          kanal_d          = secilen;
          adr_d            = cek_adr_i[int'(secilen)*ADRES_BIT +: ADRES_BIT];
          veri_d           = cek_veri_i[int'(secilen)*VERI_BIT +: VERI_BIT];
          maske_d          = cek_veri_maske_i[int'(secilen)*MW +: MW];
          bekleme_sayaci_d = '0;
        end
      end
      MESGUL: begin
        if (!bel_durdur_i) begin
          yanit_veri_d = bel_veri_i;
          durum_d      = YANIT;
        end else if ((ZAMAN_ASIMI > 0) && (bekleme_sayaci_q == SW'(ZAMAN_ASIMI))) begin
          // Abort: the core is released with zero data and the error flagged.
          yanit_veri_d = '0;
          hata_d       = 1'b1;
          hata_kanal_d = kanal_q;
          durum_d      = YANIT;
        end else if (bekleme_sayaci_q != '1) begin
          bekleme_sayaci_d = bekleme_sayaci_q + 1'b1;
        end
      end
      YANIT: begin
        durum_d   = BOS;
        oncelik_d = (kanal_q == KW'(N - 1)) ? '0 : kanal_q + 1'b1;
      end
      default: durum_d = BOS;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q          <= BOS;
      oncelik_q        <= '0;
      kanal_q          <= '0;
      adr_q            <= '0;
      veri_q           <= '0;
      maske_q          <= '0;
      yanit_veri_q     <= '0;
      bekleme_sayaci_q <= '0;
      hata_q           <= 1'b0;
      hata_kanal_q     <= '0;
    end else begin
      durum_q          <= durum_d;
      oncelik_q        <= oncelik_d;
      kanal_q          <= kanal_d;
      adr_q            <= adr_d;
      veri_q           <= veri_d;
      maske_q          <= maske_d;
      yanit_veri_q     <= yanit_veri_d;
      bekleme_sayaci_q <= bekleme_sayaci_d;
      hata_q           <= hata_d;
      hata_kanal_q     <= hata_kanal_d;
    end
  end

  assign bel_sec_o        = (durum_q == MESGUL);
  assign bel_adr_o        = adr_q;
  assign bel_veri_o       = veri_q;
  assign bel_veri_maske_o = maske_q;
  assign hata_o           = hata_q;
  assign hata_kanal_o     = hata_kanal_q;

  // Stall follows the request line except for the granted channel's
  // release cycle; only that channel sees read data.
  always_comb begin
    cek_durdur_o = cek_sec_i;
    cek_veri_o   = '0;
    if (durum_q == YANIT) begin
      cek_durdur_o[kanal_q]                          = 1'b0;
      cek_veri_o[int'(kanal_q)*VERI_BIT +: VERI_BIT] = yanit_veri_q;
    end
  end

endmodule

// File: tb/tb_bib_veri_hakemi.sv
module tb_bib_veri_hakemi;

  localparam int N  = 2;
  localparam int VB = 32;
  localparam int AB = 32;
  localparam int ZA = 8;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    cek_sec_i;
  logic [N*AB-1:0] cek_adr_i;
  logic [N*VB-1:0] cek_veri_i;
  logic [N*VB/8-1:0] cek_veri_maske_i;
  logic [N*VB-1:0] cek_veri_o;
  logic [N-1:0]    cek_durdur_o;
  logic            bel_sec_o;
  logic [AB-1:0]   bel_adr_o;
  logic [VB-1:0]   bel_veri_o;
  logic [VB/8-1:0] bel_veri_maske_o;
  logic [VB-1:0]   bel_veri_i;
  logic            bel_durdur_i;
  logic            hata_o;
  logic [0:0]      hata_kanal_o;

  int checks = 0;
  int failures = 0;

  bib_veri_hakemi #(
    .CEKIRDEK_SAYISI(N), .VERI_BIT(VB), .ADRES_BIT(AB), .ZAMAN_ASIMI(ZA)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cek_sec_i(cek_sec_i), .cek_adr_i(cek_adr_i), .cek_veri_i(cek_veri_i),
    .cek_veri_maske_i(cek_veri_maske_i), .cek_veri_o(cek_veri_o),
    .cek_durdur_o(cek_durdur_o), .bel_sec_o(bel_sec_o), .bel_adr_o(bel_adr_o),
    .bel_veri_o(bel_veri_o), .bel_veri_maske_o(bel_veri_maske_o),
    .bel_veri_i(bel_veri_i), .bel_durdur_i(bel_durdur_i),
    .hata_o(hata_o), .hata_kanal_o(hata_kanal_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    cek_sec_i = '0;
    cek_adr_i = '0;
    cek_veri_i = '0;
    cek_veri_maske_i = '0;
    bel_veri_i = '0;
    bel_durdur_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("rst_bel_sec", 64'(bel_sec_o), 64'd0);
    chk("rst_hata", 64'(hata_o), 64'd0);
    chk("rst_hata_kanal", 64'(hata_kanal_o), 64'd0);
    chk("rst_durdur", 64'(cek_durdur_o), 64'd0);
    chk("rst_cek_veri", cek_veri_o, 64'd0);

    // Single read on ch0, zero-wait memory
    cek_sec_i = 2'b01;
    cek_adr_i[31:0] = 32'h100;
    bel_veri_i = 32'hDEADBEEF;
    #1;
    chk("rd_c0_durdur", 64'(cek_durdur_o), 64'b01);
    chk("rd_c0_bel_sec", 64'(bel_sec_o), 64'd0);
    tick(); #1;
    chk("rd_c1_bel_sec", 64'(bel_sec_o), 64'd1);
    chk("rd_c1_adr", 64'(bel_adr_o), 64'h100);
    chk("rd_c1_maske", 64'(bel_veri_maske_o), 64'h0);
    chk("rd_c1_durdur", 64'(cek_durdur_o), 64'b01);
    tick(); #1;
    chk("rd_c2_bel_sec", 64'(bel_sec_o), 64'd0);
    chk("rd_c2_durdur", 64'(cek_durdur_o), 64'b00);
    chk("rd_c2_veri", cek_veri_o, 64'h0000_0000_DEAD_BEEF);
    cek_sec_i = 2'b00;
    tick(); #1;
    chk("rd_c3_bel_sec", 64'(bel_sec_o), 64'd0);
    chk("rd_c3_durdur", 64'(cek_durdur_o), 64'b00);

    // Contention: round-robin alternation from oncelik=0
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cek_adr_i = {32'h20, 32'h10};
    cek_sec_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("rr_bos_bel_sec", 64'(bel_sec_o), 64'd0);
      tick();
      bel_veri_i = 32'hA0 + 32'(t);
      #1;
      chk("rr_mesgul_bel_sec", 64'(bel_sec_o), 64'd1);
      chk("rr_mesgul_adr", 64'(bel_adr_o), (t % 2 == 1) ? 64'h20 : 64'h10);
      tick(); #1;
      chk("rr_yanit_durdur", 64'(cek_durdur_o), (t % 2 == 1) ? 64'b01 : 64'b10);
      chk("rr_yanit_veri", cek_veri_o,
          (t % 2 == 1) ? {32'hA0 + 32'(t), 32'h0} : {32'h0, 32'hA0 + 32'(t)});
      if (t == 3) cek_sec_i = 2'b00;
      tick();
    end

    // Write with 3-cycle downstream stall on ch1
    cek_sec_i = 2'b10;
    cek_adr_i[63:32] = 32'h2000;
    cek_veri_i[63:32] = 32'h12345678;
    cek_veri_maske_i[7:4] = 4'hF;
    bel_durdur_i = 1'b1;
    #1;
    chk("wr_grant_durdur", 64'(cek_durdur_o), 64'b10);
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        bel_durdur_i = 1'b0;
        bel_veri_i = 32'h5A5A;
      end
      #1;
      chk("wr_bel_sec", 64'(bel_sec_o), 64'd1);
      chk("wr_adr", 64'(bel_adr_o), 64'h2000);
      chk("wr_veri", 64'(bel_veri_o), 64'h12345678);
      chk("wr_maske", 64'(bel_veri_maske_o), 64'hF);
      chk("wr_durdur_held", 64'(cek_durdur_o), 64'b10);
      tick();
    end
    #1;
    chk("wr_release_durdur", 64'(cek_durdur_o), 64'b00);
    chk("wr_release_veri", cek_veri_o, {32'h5A5A, 32'h0});
    chk("wr_no_hata", 64'(hata_o), 64'd0);
    cek_sec_i = 2'b00;
    tick();

    // Timeout on ch1 with ch0 pending
    cek_veri_maske_i = '0;
    cek_adr_i = {32'h3000, 32'h40};
    cek_sec_i = 2'b10;
    bel_durdur_i = 1'b1;
    bel_veri_i = 32'hFFFF_FFFF;
    tick();
    cek_sec_i = 2'b11;
    for (int c = 1; c <= ZA + 1; c++) begin
      #1;
      chk("to_bel_sec", 64'(bel_sec_o), 64'd1);
      chk("to_no_hata_yet", 64'(hata_o), 64'd0);
      chk("to_durdur_held", 64'(cek_durdur_o), 64'b11);
      tick();
    end
    #1;
    chk("to_hata", 64'(hata_o), 64'd1);
    chk("to_hata_kanal", 64'(hata_kanal_o), 64'd1);
    chk("to_release_durdur", 64'(cek_durdur_o), 64'b01);
    chk("to_release_veri", cek_veri_o, 64'd0);
    cek_sec_i = 2'b01;
    bel_durdur_i = 1'b0;
    bel_veri_i = 32'hCAFEF00D;
    tick(); #1;
    chk("to_hata_pulse_end", 64'(hata_o), 64'd0);
    chk("to_hata_kanal_held", 64'(hata_kanal_o), 64'd1);
    chk("to_bos_bel_sec", 64'(bel_sec_o), 64'd0);
    tick(); #1;
    chk("to_ch0_adr", 64'(bel_adr_o), 64'h40);
    tick(); #1;
    chk("to_ch0_durdur", 64'(cek_durdur_o), 64'b00);
    chk("to_ch0_veri", cek_veri_o, {32'h0, 32'hCAFEF00D});
    cek_sec_i = 2'b00;
    tick();

    // Reset during MESGUL (oncelik is 1 here before the reset)
    cek_adr_i = {32'h600, 32'h300};
    cek_sec_i = 2'b01;
    bel_durdur_i = 1'b1;
    tick(); #1;
    chk("mr_bel_sec_before", 64'(bel_sec_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cek_sec_i = 2'b11;
    bel_durdur_i = 1'b0;
    bel_veri_i = 32'h77;
    #1;
    chk("mr_bel_sec_after", 64'(bel_sec_o), 64'd0);
    chk("mr_hata", 64'(hata_o), 64'd0);
    chk("mr_hata_kanal_cleared", 64'(hata_kanal_o), 64'd0);
    chk("mr_durdur", 64'(cek_durdur_o), 64'b11);
    chk("mr_cek_veri", cek_veri_o, 64'd0);
    tick(); #1;
    chk("mr_grant_order_adr", 64'(bel_adr_o), 64'h300);
    chk("mr_mesgul_durdur", 64'(cek_durdur_o), 64'b11);
    tick(); #1;
    chk("mr_release_durdur", 64'(cek_durdur_o), 64'b10);
    cek_sec_i = 2'b00;
    tick();

    // Idle
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("idle_durdur", 64'(cek_durdur_o), 64'b00);
      chk("idle_bel_sec", 64'(bel_sec_o), 64'd0);
      chk("idle_cek_veri", cek_veri_o, 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
